// File: rtl/ram_dma_ci_bus.sv
// Custom-instruction scratchpad with a DMA engine that moves word blocks between the scratchpad and a burst bus.
// States: IDLE wait | REQUEST bus req | BEGIN addr/size | READ/WRITE beats | END burst done | ERROR bus error abort
module ram_dma_ci_bus #(
    parameter logic [7:0] CUSTOM_ID  = 8'd14,
    parameter int         ADDR_WIDTH = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        requestTransaction,
    input  logic        transactionGranted,
    output logic        beginTransactionOut,
    output logic [31:0] addressDataOut,
    output logic [7:0]  burstSizeOut,
    output logic        readNotWriteOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busyIn,
    input  logic        busErrorIn
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (ADDR_WIDTH + 1 > 9) ? ADDR_WIDTH + 1 : 9;

    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_BEGIN, S_READ, S_WRITE, S_END, S_ERROR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_cfg_bus;
    logic [ADDR_WIDTH-1:0] r_cfg_sp;
    logic [ADDR_WIDTH:0]   r_cfg_size;
    logic [7:0]            r_cfg_burst;
    logic [31:0]           r_bus_addr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [7:0]            r_burst;
    logic [CW-1:0]         r_beat_cnt;
    logic                  r_dir_rd;
    logic                  r_error;
    logic                  r_done;
    logic [31:0]           r_result;

    logic                  w_hit;
    logic                  w_wr;
    logic [2:0]            w_op;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_ctl_go;
    logic                  w_active;
    logic                  w_dma_wr;
    logic [CW-1:0]         w_rem_ext;
    logic [CW-1:0]         w_bst_ext;
    logic [CW-1:0]         w_beats;
    logic [CW-1:0]         w_bsz;
    logic [31:0]           w_mem_rd;
    logic [31:0]           w_rd_val;
    logic                  w_unused;

    assign w_hit    = start && (ciN == CUSTOM_ID);
    assign w_addr   = valueA[ADDR_WIDTH-1:0];
    assign w_wr     = valueA[ADDR_WIDTH];
    assign w_op     = valueA[ADDR_WIDTH+3:ADDR_WIDTH+1];
    assign w_active = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign w_ctl_go = w_hit && w_wr && (w_op == 3'd5) && (r_state == S_IDLE)
                      && (r_cfg_size != '0)
                      && ((valueB[1:0] == 2'b01) || (valueB[1:0] == 2'b10));

    // Beats in the next burst: whatever is left, capped by the burst setting.
    assign w_rem_ext = CW'(r_remaining);
    assign w_bst_ext = CW'(r_burst) + CW'(1);
    assign w_beats   = (w_rem_ext < w_bst_ext) ? w_rem_ext : w_bst_ext;
    assign w_bsz     = w_beats - CW'(1);
    assign w_mem_rd  = r_mem[r_ptr];
    assign w_dma_wr  = !reset && (r_state == S_READ) && dataValidIn && (r_remaining != '0);
    assign w_unused  = ^{valueA[31:ADDR_WIDTH+4], w_bsz[CW-1:8]};

    assign done   = r_done;
    assign result = r_result;

    always_comb begin
        w_rd_val = '0;
        if (!w_wr) begin
            case (w_op)
                3'd0:    w_rd_val = r_mem[w_addr];
                3'd1:    w_rd_val = r_cfg_bus;
                3'd2:    w_rd_val = 32'(r_cfg_sp);
                3'd3:    w_rd_val = 32'(r_cfg_size);
                3'd4:    w_rd_val = 32'(r_cfg_burst);
                3'd5:    w_rd_val = {30'b0, r_error, w_active};
                default: w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_done      <= 1'b0;
            r_result    <= '0;
            r_cfg_bus   <= '0;
            r_cfg_sp    <= '0;
            r_cfg_size  <= '0;
            r_cfg_burst <= '0;
        end else begin
            r_done   <= w_hit;
            r_result <= w_hit ? w_rd_val : '0;
            if (w_hit && w_wr) begin
                case (w_op)
                    3'd1:    r_cfg_bus   <= {valueB[31:2], 2'b00};
                    3'd2:    r_cfg_sp    <= valueB[ADDR_WIDTH-1:0];
                    3'd3:    r_cfg_size  <= valueB[ADDR_WIDTH:0];
                    3'd4:    r_cfg_burst <= valueB[7:0];
                    default: ;
                endcase
            end
        end
    end

    // DMA write comes second so it wins a same-address collision with the CPU.
    always_ff @(posedge clock) begin
        if (w_hit && w_wr && (w_op == 3'd0))
            r_mem[w_addr] <= valueB;
        if (w_dma_wr)
            r_mem[r_ptr] <= addressDataIn;
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next              = r_state;
        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        addressDataOut      = '0;
        burstSizeOut        = '0;
        readNotWriteOut     = 1'b0;
        dataValidOut        = 1'b0;
        endTransactionOut   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ctl_go)
                    w_next = S_REQUEST;
            end
            S_REQUEST: begin
                requestTransaction = 1'b1;
                if (transactionGranted)
                    w_next = S_BEGIN;
            end
            S_BEGIN: begin
                beginTransactionOut = 1'b1;
                addressDataOut      = r_bus_addr;
                burstSizeOut        = w_bsz[7:0];
                readNotWriteOut     = r_dir_rd;
                w_next              = r_dir_rd ? S_READ : S_WRITE;
            end
            S_READ: begin
                if (endTransactionIn)
                    w_next = S_END;
            end
            S_WRITE: begin
                dataValidOut   = 1'b1;
                addressDataOut = w_mem_rd;
                if (!busyIn && (r_beat_cnt == CW'(1)))
                    w_next = S_END;
            end
            S_END: begin
                endTransactionOut = !r_dir_rd;
                w_next            = (r_remaining != '0) ? S_REQUEST : S_IDLE;
            end
            S_ERROR: begin
                endTransactionOut = 1'b1;
                w_next            = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_active && busErrorIn)
            w_next = S_ERROR;
    end

    // Working copies are taken at start so config writes during a transfer wait for the next one.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bus_addr  <= '0;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_burst     <= '0;
            r_beat_cnt  <= '0;
            r_dir_rd    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_ctl_go) begin
                r_error     <= 1'b0;
                r_dir_rd    <= (valueB[1:0] == 2'b01);
                r_bus_addr  <= r_cfg_bus;
                r_ptr       <= r_cfg_sp;
                r_remaining <= r_cfg_size;
                r_burst     <= r_cfg_burst;
            end
            if (w_active && busErrorIn)
                r_error <= 1'b1;
            case (r_state)
                S_BEGIN: begin
                    r_beat_cnt <= w_beats;
                    r_bus_addr <= r_bus_addr + (32'(w_beats) << 2);
                end
                S_READ: begin
                    if (dataValidIn && (r_remaining != '0)) begin
                        r_ptr       <= r_ptr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
                    end
                end
                S_WRITE: begin
                    if (!busyIn) begin
                        r_ptr       <= r_ptr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
                        r_beat_cnt  <= r_beat_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_dma_ci_bus.sv
// Randomized bench for ram_dma_ci_bus: CPU instructions and a bus slave are driven from here and
// compared against a word-array model of the scratchpad and a burst-by-burst transfer model.
module tb_ram_dma_ci_bus;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [7:0]  ciN;
    logic [31:0] valueA, valueB;
    logic        done;
    logic [31:0] result;
    logic        requestTransaction, transactionGranted, beginTransactionOut;
    logic [31:0] addressDataOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut, dataValidOut, endTransactionOut;
    logic [31:0] addressDataIn;
    logic        dataValidIn, endTransactionIn, busyIn, busErrorIn;

    ram_dma_ci_bus #(.CUSTOM_ID(8'd14), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done), .result(result),
        .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
        .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
        .burstSizeOut(burstSizeOut), .readNotWriteOut(readNotWriteOut),
        .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
        .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .busyIn(busyIn), .busErrorIn(busErrorIn)
    );

    always #5 clock = ~clock;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] m_cfg [1:4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cmd(input int op, input bit wr, input int addr);
        return (32'(op) << (AW + 1)) | (32'(wr) << AW) | (32'(addr) & 32'(DEPTH - 1));
    endfunction

    function automatic logic [31:0] cfg_mask(input int op);
        case (op)
            1:       return 32'hFFFF_FFFC;
            2:       return 32'(DEPTH - 1);
            3:       return 32'(2 * DEPTH - 1);
            default: return 32'h0000_00FF;
        endcase
    endfunction

    task automatic ci_exec(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res);
        logic d1, d2;
        logic [31:0] r2;
        @(negedge clock);
        start = 1'b1; ciN = n; valueA = a; valueB = b;
        @(negedge clock);
        start = 1'b0;
        d1  = done;
        res = result;
        @(negedge clock);
        d2 = done;
        r2 = result;
        if (n == 8'd14) begin
            check_eq("done_pulse", 32'(d1), 32'd1);
        end else begin
            check_eq("done_foreign", 32'(d1), 32'd0);
            check_eq("result_foreign", res, 32'd0);
        end
        check_eq("done_one_cycle", 32'(d2), 32'd0);
        check_eq("result_idle", r2, 32'd0);
    endtask

    task automatic sp_write(input int addr, input logic [31:0] data);
        logic [31:0] res;
        ci_exec(8'd14, cmd(0, 1'b1, addr), data, res);
        model_mem[addr % DEPTH] = data;
    endtask

    task automatic sp_check(input string tag, input int addr);
        logic [31:0] res;
        ci_exec(8'd14, cmd(0, 1'b0, addr), 32'd0, res);
        check_eq(tag, res, model_mem[addr % DEPTH]);
    endtask

    task automatic status_check(input string tag, input logic [31:0] exp);
        logic [31:0] res;
        ci_exec(8'd14, cmd(5, 1'b0, 0), 32'd0, res);
        check_eq(tag, res, exp);
    endtask

    task automatic wait_request(output bit ok);
        int to = 0;
        while (!requestTransaction && to < 50) begin
            @(negedge clock);
            to++;
        end
        ok = requestTransaction;
        check_eq("req_seen", 32'(requestTransaction), 32'd1);
    endtask

    task automatic configure(input bit rd, input logic [31:0] baddr, input int sp,
                             input int size, input int burst);
        logic [31:0] res;
        ci_exec(8'd14, cmd(1, 1'b1, 0), baddr, res);
        ci_exec(8'd14, cmd(2, 1'b1, 0), 32'(sp), res);
        ci_exec(8'd14, cmd(3, 1'b1, 0), 32'(size), res);
        ci_exec(8'd14, cmd(4, 1'b1, 0), 32'(burst), res);
        ci_exec(8'd14, cmd(5, 1'b1, 0), rd ? 32'd1 : 32'd2, res);
    endtask

    // Whole transfer: the model splits the block into bursts and plays the slave for each.
    task automatic run_dma(input bit rd, input logic [31:0] baddr, input int sp, input int size,
                           input int burst, input int stall_at, input int stall_len);
        int rem, ptr, beats, k, stalls, to;
        logic [31:0] a, d;
        bit ok;
        configure(rd, baddr, sp, size, burst);
        rem = size;
        a   = baddr & 32'hFFFF_FFFC;
        ptr = sp;
        while (rem > 0) begin
            beats = (rem < burst + 1) ? rem : burst + 1;
            wait_request(ok);
            if (!ok) return;
            transactionGranted = 1'b1;
            @(negedge clock);
            transactionGranted = 1'b0;
            check_eq("begin", 32'(beginTransactionOut), 32'd1);
            check_eq("begin_addr", addressDataOut, a);
            check_eq("burst_size", 32'(burstSizeOut), 32'(beats - 1));
            check_eq("rnw", 32'(readNotWriteOut), 32'(rd));
            if (rd) begin
                for (int i = 0; i < beats; i++) begin
                    @(negedge clock);
                    d = $urandom;
                    dataValidIn      = 1'b1;
                    addressDataIn    = d;
                    endTransactionIn = (i == beats - 1);
                    model_mem[(ptr + i) % DEPTH] = d;
                end
                @(negedge clock);
                dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
                check_eq("rd_no_end_out", 32'(endTransactionOut), 32'd0);
            end else begin
                k = 0; stalls = 0; to = 0;
                while (k < beats && to < 100) begin
                    @(negedge clock);
                    to++;
                    check_eq("wr_valid", 32'(dataValidOut), 32'd1);
                    check_eq("wr_data", addressDataOut, model_mem[(ptr + k) % DEPTH]);
                    if (k == stall_at && stalls < stall_len) begin
                        busyIn = 1'b1;
                        stalls++;
                    end else begin
                        busyIn = 1'b0;
                        k++;
                    end
                end
                @(negedge clock);
                busyIn = 1'b0;
                check_eq("wr_end_out", 32'(endTransactionOut), 32'd1);
                check_eq("wr_valid_after", 32'(dataValidOut), 32'd0);
            end
            a   = a + 32'(4 * beats);
            ptr = (ptr + beats) % DEPTH;
            rem = rem - beats;
        end
        @(negedge clock);
        check_eq("end_out_single", 32'(endTransactionOut), 32'd0);
        status_check("status_after", 32'd0);
        if (rd)
            for (int i = 0; i < size; i++) sp_check("dma_rd_data", sp + i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit hit, required a finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, d;
        bit ok;
        int r, op, addr;
        logic [7:0] n;

        reset = 1'b1; start = 1'b0; ciN = '0; valueA = '0; valueB = '0;
        transactionGranted = 1'b0; addressDataIn = '0; dataValidIn = 1'b0;
        endTransactionIn = 1'b0; busyIn = 1'b0; busErrorIn = 1'b0;
        for (int i = 1; i <= 4; i++) m_cfg[i] = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_req", 32'(requestTransaction), 32'd0);
        check_eq("rst_begin", 32'(beginTransactionOut), 32'd0);
        check_eq("rst_valid", 32'(dataValidOut), 32'd0);
        check_eq("rst_end", 32'(endTransactionOut), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ci_exec(8'd14, cmd(i, 1'b0, 0), 32'd0, res);
            check_eq("rst_cfg", res, 32'd0);
        end

        sp_write(3, 32'hA5A5_0001);
        ci_exec(8'd14, 32'h0000_0003, 32'd0, res);
        check_eq("sp_rd_3", res, 32'hA5A5_0001);

        ci_exec(8'd13, 32'h0000_0203, 32'h1234_5678, res);
        sp_check("foreign_no_write", 3);

        for (int it = 0; it < 40; it++) begin
            r    = $urandom_range(0, 9);
            addr = $urandom_range(0, DEPTH - 1);
            d    = $urandom;
            if (r < 4) begin
                sp_write(addr, d);
            end else if (r < 7) begin
                sp_check("rand_sp_rd", addr);
            end else if (r == 7) begin
                op = $urandom_range(1, 4);
                ci_exec(8'd14, cmd(op, 1'b1, 0), d, res);
                m_cfg[op] = d & cfg_mask(op);
                ci_exec(8'd14, cmd(op, 1'b0, 0), 32'd0, res);
                check_eq("rand_cfg_rd", res, m_cfg[op]);
            end else if (r == 8) begin
                op = $urandom_range(6, 7);
                ci_exec(8'd14, cmd(op, 1'b0, addr), d, res);
                check_eq("op67_zero", res, 32'd0);
            end else begin
                n = 8'($urandom_range(0, 255));
                if (n == 8'd14) n = 8'd15;
                ci_exec(n, cmd(0, 1'b1, addr), d, res);
                sp_check("rand_foreign", addr);
            end
        end

        run_dma(1'b1, 32'h0000_0100, 510, 4, 1, -1, 0);

        for (int i = 0; i < 3; i++) sp_write(20 + i, $urandom);
        run_dma(1'b0, 32'h0000_0040, 20, 3, 7, 1, 2);

        configure(1'b1, 32'h0000_0200, 100, 4, 3);
        status_check("status_busy", 32'd1);
        wait_request(ok);
        transactionGranted = 1'b1;
        @(negedge clock);
        transactionGranted = 1'b0;
        check_eq("err_burst_size", 32'(burstSizeOut), 32'd3);
        @(negedge clock);
        d = $urandom;
        dataValidIn = 1'b1; addressDataIn = d;
        model_mem[100] = d;
        @(negedge clock);
        dataValidIn = 1'b0; addressDataIn = '0; busErrorIn = 1'b1;
        @(negedge clock);
        busErrorIn = 1'b0;
        check_eq("err_end_out", 32'(endTransactionOut), 32'd1);
        check_eq("err_no_req", 32'(requestTransaction), 32'd0);
        @(negedge clock);
        check_eq("err_end_once", 32'(endTransactionOut), 32'd0);
        status_check("status_error", 32'd2);
        sp_check("err_first_beat", 100);
        run_dma(1'b1, 32'h0000_0300, 200, 2, 3, -1, 0);

        configure(1'b0, 32'h0000_0400, 20, 6, 7);
        wait_request(ok);
        transactionGranted = 1'b1;
        @(negedge clock);
        transactionGranted = 1'b0;
        @(negedge clock);
        check_eq("rm_valid", 32'(dataValidOut), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("rm_req", 32'(requestTransaction), 32'd0);
        check_eq("rm_begin", 32'(beginTransactionOut), 32'd0);
        check_eq("rm_addr", addressDataOut, 32'd0);
        check_eq("rm_bsz", 32'(burstSizeOut), 32'd0);
        check_eq("rm_rnw", 32'(readNotWriteOut), 32'd0);
        check_eq("rm_valid0", 32'(dataValidOut), 32'd0);
        check_eq("rm_end", 32'(endTransactionOut), 32'd0);
        check_eq("rm_done", 32'(done), 32'd0);
        for (int i = 1; i <= 4; i++) m_cfg[i] = '0;
        status_check("rm_status", 32'd0);
        ci_exec(8'd14, cmd(5, 1'b1, 0), 32'd2, res);
        check_eq("size0_ignored", 32'(requestTransaction), 32'd0);
        status_check("size0_status", 32'd0);
        sp_check("rm_sp_kept", 20);

        for (int rnd = 0; rnd < 4; rnd++) begin
            bit rd;
            int sp, size, burst;
            rd    = 1'($urandom_range(0, 1));
            sp    = $urandom_range(0, DEPTH - 1);
            size  = $urandom_range(1, 6);
            burst = $urandom_range(0, 3);
            if (!rd)
                for (int i = 0; i < size; i++) sp_write((sp + i) % DEPTH, $urandom);
            run_dma(rd, $urandom, sp, size, burst, $urandom_range(0, 1), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_dma_ci_bus.md
RAM_DMA_CI_BUS -- requirements
Module: ram_dma_ci_bus

Interface
REQ-001 SHALL have parameter CUSTOM_ID, default 8'd14, the custom-instruction number this block answers.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, scratchpad depth = 2^ADDR_WIDTH 32-bit words, legal range 6..12.
REQ-003 SHALL have clock  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have reset  in  1  synchronous, active-high.
REQ-005 SHALL have start  in  1  custom-instruction strobe.
REQ-006 SHALL have ciN  in  8  custom-instruction number.
REQ-007 SHALL have valueA  in  32  command word: [ADDR_WIDTH-1:0] addr, [ADDR_WIDTH] write, [ADDR_WIDTH+3:ADDR_WIDTH+1] op.
REQ-008 SHALL have valueB  in  32  write data.
REQ-009 SHALL have done  out  1  instruction complete.
REQ-010 SHALL have result  out  32  read data.
REQ-011 SHALL have requestTransaction  out  1  bus request.
REQ-012 SHALL have transactionGranted  in  1  bus grant.
REQ-013 SHALL have beginTransactionOut  out  1  transaction start strobe.
REQ-014 SHALL have addressDataOut  out  32  address on begin, data on write beats.
REQ-015 SHALL have burstSizeOut  out  8  beats minus one.
REQ-016 SHALL have readNotWriteOut  out  1  1 = bus read.
REQ-017 SHALL have dataValidOut  out  1  write beat valid.
REQ-018 SHALL have endTransactionOut  out  1  master end strobe.
REQ-019 SHALL have addressDataIn  in  32  read data.
REQ-020 SHALL have dataValidIn  in  1  read beat valid.
REQ-021 SHALL have endTransactionIn  in  1  slave end strobe.
REQ-022 SHALL have busyIn  in  1  slave stall; write beat held while high.
REQ-023 SHALL have busErrorIn  in  1  bus error.

Function
REQ-024 SHALL act only when start=1 and ciN=CUSTOM_ID; done pulses exactly one cycle, the cycle after start; result=0 whenever done=0.
REQ-025 SHALL decode op: 0 scratchpad, 1 bus start address, 2 scratchpad start address, 3 block size (words, ADDR_WIDTH+1 bits), 4 burst size (8 bits, beats = value+1), 5 control/status; ops 6-7 no effect, result 0.
REQ-026 SHALL, for op 0, write valueB to scratchpad[addr] when write=1, else return scratchpad[addr] on result with done.
REQ-027 SHALL, for ops 1-4, load register from valueB when write=1, else return it zero-extended; bus address bits [1:0] forced 0.
REQ-028 SHALL, for op 5 write, start transfer: valueB[1:0]=01 bus->scratchpad, 10 scratchpad->bus, others ignored; read returns {30'b0, error, busy}.
REQ-029 SHALL ignore control writes while busy or when block size=0; register writes while busy take effect on the next transfer (values latched at start).
REQ-030 SHALL implement FSM IDLE -> REQUEST -> BEGIN -> (READ or WRITE) -> END -> REQUEST if words remain, else IDLE; any state -> ERROR -> IDLE.
REQ-031 SHALL hold requestTransaction in REQUEST until transactionGranted, then pulse beginTransactionOut one cycle with address, burstSizeOut = min(remaining, burst+1)-1, direction.
REQ-032 SHALL, in READ, store addressDataIn at scratchpad pointer on each dataValidIn, pointer +1, remaining -1, leave READ on endTransactionIn.
REQ-033 SHALL, in WRITE, drive one beat per cycle with busyIn=0, hold data/dataValidOut while busyIn=1, pulse endTransactionOut one cycle after the last beat.
REQ-034 SHALL advance bus address by 4*beats per burst; scratchpad pointer wraps modulo 2^ADDR_WIDTH.
REQ-035 SHALL, on busErrorIn, set error, pulse endTransactionOut, drop busy, return IDLE; error clears on next accepted start.
REQ-036 SHALL use a dual-port scratchpad; same-cycle same-address CPU and DMA writes store DMA data; read-during-write returns old data.

Reset
REQ-037 SHALL on reset zero all outputs, registers, error and busy, enter IDLE, abort any transfer without endTransactionOut; scratchpad contents undefined-preserved.

Verification
REQ-038 SHALL verify: write 0xA5A5_0001 at addr 3 (valueA=0x203), read valueA=0x003 -> result 0xA5A5_0001, done one cycle.
REQ-039 SHALL verify: start with ciN=13 -> done stays 0, scratchpad unchanged.
REQ-040 SHALL verify: bus addr 0x100, mem addr 510, size 4, burst 1, bus->scratchpad -> two 2-beat bursts at 0x100/0x108, data lands at 510,511,0,1.
REQ-041 SHALL verify: scratchpad->bus size 3, burst 7, busyIn high 2 cycles mid-burst -> burstSizeOut=2, data held, one endTransactionOut.
REQ-042 SHALL verify: busErrorIn during read burst -> status reads 0x2, later transfer starts cleanly; reset mid-burst -> all bus outputs 0 next cycle.
